// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a valid/ready data bus with one outstanding access.
// Optional macro MEM_MISALIGNED_TRAP_EN turns misaligned halfword/word accesses into traps.
module mem_stage #(
  parameter int RESP_TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [248:0] ex_mem_pipeline_q,
  input  logic         mem_flush_i,
  output logic         mem_stall_o,
  output logic [280:0] mem_wb_pipeline_q,
  output logic         dmem_valid_o,
  input  logic         dmem_ready_i,
  output logic [31:0]  dmem_addr_o,
  output logic         dmem_we_o,
  output logic [3:0]   dmem_be_o,
  output logic [31:0]  dmem_wdata_o,
  input  logic         dmem_rvalid_i,
  input  logic [31:0]  dmem_rdata_i
);

  typedef struct packed {
    logic        valid;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] alu_csr_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] pc_plus_4;
    logic        result_sel;
    logic        trap_valid;
    logic [31:0] trap_mcause;
    logic [31:0] trap_mtval;
  } ex_mem_t;

  typedef struct packed {
    ex_mem_t     em;
    logic [31:0] load_rdata;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(RESP_TIMEOUT - 1);

  function automatic logic [3:0] be_fn(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   be_fn = 4'b0001 << off;
      2'b01:   be_fn = 4'b0011 << off;
      2'b10:   be_fn = 4'b1111;
      default: be_fn = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_fn(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   wdata_fn = {4{sd[7:0]}};
      2'b01:   wdata_fn = {2{sd[15:0]}};
      default: wdata_fn = sd;
    endcase
  endfunction

  function automatic logic [31:0] load_fn(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (f3)
      3'b000:  load_fn = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_fn = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_fn = {24'h000000, sh[7:0]};
      3'b101:  load_fn = {16'h0000, sh[15:0]};
      default: load_fn = raw;
    endcase
  endfunction

  ex_mem_t     in_s;
  ex_mem_t     req_r;
  mem_wb_t     mem_wb_r;
  mem_wb_t     pass_s;
  mem_wb_t     done_s;
  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        kill_r;
  logic        mis_s;
  logic        issue_s;
  logic        timeout_s;
  logic [31:0] bus_addr_s;
  logic [2:0]  bus_f3_s;
  logic [31:0] bus_sd_s;
  logic        bus_we_s;

  assign in_s              = ex_mem_pipeline_q;
  assign mem_wb_pipeline_q = mem_wb_r;

  // Alignment check on the incoming access
`ifdef MEM_MISALIGNED_TRAP_EN
  always_comb begin
    mis_s = 1'b0;
    if (in_s.valid && in_s.mem_req && !in_s.trap_valid) begin
      case (in_s.mem_funct3[1:0])
        2'b01:   mis_s = in_s.alu_csr_result[0];
        2'b10:   mis_s = (in_s.alu_csr_result[1:0] != 2'b00);
        default: mis_s = 1'b0;
      endcase
    end else begin
      mis_s = 1'b0;
    end
  end
`else
  assign mis_s = 1'b0;
`endif

  assign issue_s   = !rst_i && (state_r == IDLE) && in_s.valid && in_s.mem_req &&
                     !in_s.trap_valid && !mis_s && !mem_flush_i;
  assign timeout_s = (state_r == WAIT_RESP) && !dmem_rvalid_i && (cnt_r == TO_LAST);

  // Bundles emitted on pass-through (possibly with alignment trap) and on access completion
  always_comb begin
    pass_s.em                = in_s;
    pass_s.load_rdata        = 32'd0;
    pass_s.em.trap_valid     = in_s.trap_valid | mis_s;
    pass_s.em.trap_mcause    = mis_s ? (in_s.mem_we ? 32'd6 : 32'd4) : in_s.trap_mcause;
    pass_s.em.trap_mtval     = mis_s ? in_s.alu_csr_result : in_s.trap_mtval;

    done_s.em = req_r;
    if (dmem_rvalid_i) begin
      done_s.load_rdata = req_r.mem_we ? 32'd0 :
                          load_fn(req_r.mem_funct3, req_r.alu_csr_result[1:0], dmem_rdata_i);
    end else begin
      done_s.load_rdata     = 32'd0;
      done_s.em.trap_valid  = 1'b1;
      done_s.em.trap_mcause = req_r.mem_we ? 32'd7 : 32'd5;
      done_s.em.trap_mtval  = req_r.alu_csr_result;
    end
  end

  // Bus request drive and stall; in IDLE the request comes straight from the incoming bundle
  always_comb begin
    if (state_r == IDLE) begin
      bus_addr_s = in_s.alu_csr_result;
      bus_f3_s   = in_s.mem_funct3;
      bus_sd_s   = in_s.store_data;
      bus_we_s   = in_s.mem_we;
    end else begin
      bus_addr_s = req_r.alu_csr_result;
      bus_f3_s   = req_r.mem_funct3;
      bus_sd_s   = req_r.store_data;
      bus_we_s   = req_r.mem_we;
    end

    if (rst_i) begin
      dmem_valid_o = 1'b0;
      mem_stall_o  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dmem_valid_o = issue_s;
          mem_stall_o  = issue_s;
        end
        REQ: begin
          dmem_valid_o = 1'b1;
          mem_stall_o  = 1'b1;
        end
        WAIT_RESP: begin
          dmem_valid_o = 1'b0;
          mem_stall_o  = !(dmem_rvalid_i || timeout_s);
        end
        default: begin
          dmem_valid_o = 1'b0;
          mem_stall_o  = 1'b0;
        end
      endcase
    end

    dmem_addr_o  = {bus_addr_s[31:2], 2'b00};
    dmem_we_o    = dmem_valid_o & bus_we_s;
    dmem_be_o    = dmem_valid_o ? be_fn(bus_f3_s, bus_addr_s[1:0]) : 4'b0000;
    dmem_wdata_o = wdata_fn(bus_f3_s, bus_sd_s);
  end

  // Stage FSM with registered MEM/WB bundle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      kill_r   <= 1'b0;
      req_r    <= '0;
      mem_wb_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r  <= 8'd0;
          kill_r <= 1'b0;
          if (issue_s) begin
            req_r    <= in_s;
            mem_wb_r <= '0;
            state_r  <= dmem_ready_i ? WAIT_RESP : REQ;
          end else if (mem_flush_i || !in_s.valid) begin
            mem_wb_r <= '0;
          end else begin
            mem_wb_r <= pass_s;
          end
        end
        REQ: begin
          mem_wb_r <= '0;
          kill_r   <= kill_r | mem_flush_i;
          if (dmem_ready_i) begin
            state_r <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dmem_rvalid_i || timeout_s) begin
            // A killed access still finishes on the bus but retires as a bubble
            mem_wb_r <= (kill_r || mem_flush_i) ? '0 : done_s;
            state_r  <= IDLE;
            kill_r   <= 1'b0;
            cnt_r    <= 8'd0;
          end else begin
            mem_wb_r <= '0;
            kill_r   <= kill_r | mem_flush_i;
            cnt_r    <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_wb_r <= '0;
          kill_r   <= 1'b0;
          cnt_r    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  typedef struct packed {
    logic        valid;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] alu_csr_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] pc_plus_4;
    logic        result_sel;
    logic        trap_valid;
    logic [31:0] trap_mcause;
    logic [31:0] trap_mtval;
  } ex_mem_t;

  typedef struct packed {
    ex_mem_t     em;
    logic [31:0] load_rdata;
  } mem_wb_t;

  logic         clk;
  logic         rst;
  logic [248:0] ex_mem;
  logic         flush;
  logic         stall;
  logic [280:0] wb_bus;
  logic         dvalid;
  logic         ready;
  logic [31:0]  daddr;
  logic         dwe;
  logic [3:0]   dbe;
  logic [31:0]  dwdata;
  logic         rvalid;
  logic [31:0]  rdata;

  int n_cmp = 0;
  int n_err = 0;

  int          st;
  logic        stab;
  logic        seen;
  logic        we0;
  logic [31:0] a0;
  logic [31:0] wd0;
  logic [3:0]  be0;
  mem_wb_t     w;

  mem_stage #(.RESP_TIMEOUT(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ex_mem_pipeline_q (ex_mem),
    .mem_flush_i       (flush),
    .mem_stall_o       (stall),
    .mem_wb_pipeline_q (wb_bus),
    .dmem_valid_o      (dvalid),
    .dmem_ready_i      (ready),
    .dmem_addr_o       (daddr),
    .dmem_we_o         (dwe),
    .dmem_be_o         (dbe),
    .dmem_wdata_o      (dwdata),
    .dmem_rvalid_i     (rvalid),
    .dmem_rdata_i      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_t mk(input logic req, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [4:0] rd);
    ex_mem_t b;
    b                = '0;
    b.valid          = 1'b1;
    b.mem_req        = req;
    b.mem_we         = we;
    b.mem_funct3     = f3;
    b.alu_csr_result = addr;
    b.store_data     = sd;
    b.rd_addr        = rd;
    b.csr_addr       = 12'h300;
    b.pc_plus_4      = 32'h0000_1004;
    return b;
  endfunction

  // Present one bundle and run the bus until the stage stops stalling (bounded).
  task automatic run_access(input ex_mem_t b, input int rdy_k, input int rsp_k, input int flush_k,
                            input logic [31:0] resp, output int stalls, output logic stable,
                            output logic vseen, output logic [31:0] a_0, output logic [3:0] be_0,
                            output logic [31:0] wd_0, output logic we_0);
    logic done;
    stalls = 0; stable = 1'b1; vseen = 1'b0; done = 1'b0;
    a_0 = 32'd0; be_0 = 4'd0; wd_0 = 32'd0; we_0 = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      ex_mem = b;
      ready  = (k == rdy_k);
      rvalid = (k == rsp_k);
      rdata  = (k == rsp_k) ? resp : 32'hA5A5_5A5A;
      flush  = (k == flush_k);
      #1;
      if (dvalid) vseen = 1'b1;
      if (k == 0) begin
        a_0 = daddr; be_0 = dbe; wd_0 = dwdata; we_0 = dwe;
      end else if (dvalid && (daddr !== a_0 || dbe !== be_0 || dwdata !== wd_0 || dwe !== we_0)) begin
        stable = 1'b0;
      end
      if (stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    check_eq("stall_bound", {31'd0, done}, 32'd1);
    ex_mem = '0; ready = 1'b0; rvalid = 1'b0; flush = 1'b0; rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_mem = '0; flush = 1'b0; ready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    ex_mem = mk(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd1);
    #1;
    check_eq("rst_wb_zero", {31'd0, |wb_bus}, 32'd0);
    check_eq("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    ex_mem = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory op: 1-cycle pass-through
    run_access(mk(1'b0, 1'b0, 3'b010, 32'h55, 32'd0, 5'd5), 0, 100, -1, 32'd0, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("alu_stall", st, 0);
    check_eq("alu_valid", {31'd0, w.em.valid}, 32'd1);
    check_eq("alu_rd", {27'd0, w.em.rd_addr}, 32'd5);
    check_eq("alu_result", w.em.alu_csr_result, 32'h55);

    // LW 0x100, ready same cycle, response next cycle
    run_access(mk(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd7), 0, 1, -1, 32'hDEADBEEF, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("lw_addr", a0, 32'h100);
    check_eq("lw_be", {28'd0, be0}, 32'hF);
    check_eq("lw_we", {31'd0, we0}, 32'd0);
    check_eq("lw_stall_cycles", st, 1);
    check_eq("lw_rdata", w.em.valid ? w.load_rdata : 32'hFFFF_FFFF, 32'hDEADBEEF);
    check_eq("lw_rd", {27'd0, w.em.rd_addr}, 32'd7);

    // Sub-word loads
    run_access(mk(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd2), 0, 1, -1, 32'h80FF_FFFF, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("lb_be", {28'd0, be0}, 32'h8);
    check_eq("lb_rdata", w.load_rdata, 32'hFFFF_FF80);
    run_access(mk(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd2), 0, 1, -1, 32'h80FF_FFFF, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("lbu_rdata", w.load_rdata, 32'h0000_0080);
    run_access(mk(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 5'd3), 0, 1, -1, 32'h8001_1234, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("lh_rdata", w.load_rdata, 32'hFFFF_8001);
    run_access(mk(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 5'd3), 0, 1, -1, 32'h8001_1234, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("lhu_rdata", w.load_rdata, 32'h0000_8001);

    // SH 0x202 with ready withheld for 3 cycles
    run_access(mk(1'b1, 1'b1, 3'b001, 32'h202, 32'h0000_1234, 5'd0), 3, 4, -1, 32'hFFFF_FFFF, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("sh_addr", a0, 32'h200);
    check_eq("sh_be", {28'd0, be0}, 32'hC);
    check_eq("sh_wdata", wd0, 32'h1234_1234);
    check_eq("sh_we", {31'd0, we0}, 32'd1);
    check_eq("sh_stable", {31'd0, stab}, 32'd1);
    check_eq("sh_stall_cycles", st, 4);
    check_eq("sh_valid", {31'd0, w.em.valid}, 32'd1);
    check_eq("sh_rdata_zero", w.load_rdata, 32'd0);

    // LW with no response: timeout trap after 16 waiting cycles
    run_access(mk(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd4), 0, 1000, -1, 32'd0, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("to_ld_stalls", st, 16);
    check_eq("to_ld_trap", {31'd0, w.em.trap_valid}, 32'd1);
    check_eq("to_ld_mcause", w.em.trap_mcause, 32'd5);
    check_eq("to_ld_mtval", w.em.trap_mtval, 32'h300);
    ex_mem = mk(1'b0, 1'b0, 3'b010, 32'h77, 32'd0, 5'd9);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    #1;
    check_eq("stray_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    w = wb_bus;
    check_eq("stray_rd", {27'd0, w.em.rd_addr}, 32'd9);
    check_eq("stray_rdata", w.load_rdata, 32'd0);
    ex_mem = '0; rvalid = 1'b0;

    run_access(mk(1'b1, 1'b1, 3'b010, 32'h304, 32'h5, 5'd0), 0, 1000, -1, 32'd0, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("to_st_mcause", w.em.trap_valid ? w.em.trap_mcause : 32'd0, 32'd7);

    // Flush while waiting for response
    run_access(mk(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd6), 0, 3, 1, 32'h1234_5678, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
    check_eq("flw_stalls", st, 3);
    check_eq("flw_bubble", {31'd0, |wb_bus}, 32'd0);
    check_eq("flw_rd", {27'd0, w.em.rd_addr}, 32'd0);
    check_eq("flw_trap", {31'd0, w.em.trap_valid}, 32'd0);

    // Flush in IDLE: no request, bubble out
    run_access(mk(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 5'd6), 0, 1, 0, 32'd0, st, stab, seen, a0, be0, wd0, we0);
    check_eq("fli_no_req", {31'd0, seen}, 32'd0);
    check_eq("fli_bubble", {31'd0, |wb_bus}, 32'd0);

    // Incoming trap never reaches the bus
    begin
      ex_mem_t tb_b;
      tb_b = mk(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 5'd1);
      tb_b.trap_valid = 1'b1; tb_b.trap_mcause = 32'd2; tb_b.trap_mtval = 32'h77;
      run_access(tb_b, 0, 1, -1, 32'd0, st, stab, seen, a0, be0, wd0, we0);
    end
    w = wb_bus;
    check_eq("trapin_no_req", {31'd0, seen}, 32'd0);
    check_eq("trapin_mcause", w.em.trap_mcause, 32'd2);

    // Misaligned word access
    run_access(mk(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd8), 0, 1, -1, 32'hCAFE_F00D, st, stab, seen, a0, be0, wd0, we0);
    w = wb_bus;
`ifdef MEM_MISALIGNED_TRAP_EN
    check_eq("mis_no_req", {31'd0, seen}, 32'd0);
    check_eq("mis_trap", {31'd0, w.em.trap_valid}, 32'd1);
    check_eq("mis_mcause", w.em.trap_mcause, 32'd4);
    check_eq("mis_mtval", w.em.trap_mtval, 32'h101);
`else
    check_eq("mis_addr", a0, 32'h100);
    check_eq("mis_be", {28'd0, be0}, 32'hF);
    check_eq("mis_rdata", w.load_rdata, 32'hCAFE_F00D);
`endif

    // Reset mid-access, response after release is ignored
    ex_mem = mk(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 5'd3);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ex_mem = '0; rvalid = 1'b1; rdata = 32'h9999_9999;
    #1;
    check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_eq("rstmid_bubble", {31'd0, |wb_bus}, 32'd0);
    rvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: RESP_TIMEOUT, default 16, cycles in WAIT_RESP without dmem_rvalid_i before an access-fault trap; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 ex_mem_pipeline_q  input  ex_mem_t  registered EX/MEM bundle: valid, mem_req, mem_we, mem_funct3[2:0], alu_csr_result[31:0] (address or result), store_data[31:0], rd_addr[4:0], csr_addr[11:0], csr_wdata[31:0], csr_rdata[31:0], pc_plus_4[31:0], result_sel, trap_valid, trap_mcause[31:0], trap_mtval[31:0].
REQ-005 mem_flush_i  input  1  kill the instruction currently in the stage.
REQ-006 mem_stall_o  output  1  stage cannot accept a new ex_mem bundle this cycle.
REQ-007 mem_wb_pipeline_q  output  mem_wb_t  registered MEM/WB bundle consumed by the writeback stage, including load_rdata[31:0].
REQ-008 dmem_valid_o / dmem_ready_i  output / input  1 / 1  request handshake.
REQ-009 dmem_addr_o  output  32  word-aligned byte address; dmem_we_o  output  1; dmem_be_o  output  4; dmem_wdata_o  output  32 (lane-shifted).
REQ-010 dmem_rvalid_i  input  1  response strobe; dmem_rdata_i  input  32  raw word.

Function
REQ-011 FSM states IDLE, REQ, WAIT_RESP; at most one outstanding access.
REQ-012 IDLE, incoming valid with mem_req=0 or trap_valid=1: bundle registered into mem_wb_pipeline_q next edge, mem_stall_o=0, 1-cycle latency.
REQ-013 IDLE, valid with mem_req=1 and no trap: dmem_valid_o asserted combinationally the same cycle, mem_stall_o=1, go to REQ (or WAIT_RESP if dmem_ready_i=1 that cycle).
REQ-014 REQ: dmem_valid_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o held stable until dmem_ready_i=1; then WAIT_RESP.
REQ-015 WAIT_RESP: dmem_rvalid_i in the same cycle as acceptance is ignored; the earliest legal response is the cycle after acceptance.
REQ-016 WAIT_RESP, dmem_rvalid_i=1: mem_stall_o=0 that cycle; mem_wb_pipeline_q captures the bundle plus load_rdata next edge; return to IDLE. Minimum load/store latency 2 cycles.
REQ-017 Stores also wait for dmem_rvalid_i (write ack); load_rdata=0 for stores.
REQ-018 Byte enables: funct3 x00 -> 4'b0001<<addr[1:0]; x01 -> 4'b0011<<addr[1:0]; 010 -> 4'b1111; store data replicated per lane.
REQ-019 Load extract: LB/LH sign-extend, LBU/LHU zero-extend the selected lane; LW pass-through.
REQ-020 Timeout: 8-bit counter increments each WAIT_RESP cycle; on reaching RESP_TIMEOUT, emit bundle with trap_valid=1, trap_mcause=5 (load) or 7 (store), trap_mtval=address; return to IDLE; a later stray dmem_rvalid_i in IDLE is ignored.
REQ-021 mem_flush_i in IDLE: next mem_wb_pipeline_q is a bubble (all fields 0); no request issued.
REQ-022 mem_flush_i in REQ or WAIT_RESP: kill flag set; access completes on the bus; resulting bundle replaced by a bubble; kill flag cleared on return to IDLE.
REQ-023 An incoming bundle already carrying trap_valid=1 never issues a bus request.

Reset
REQ-024 rst_i=1: state IDLE, counter 0, kill flag 0, mem_wb_pipeline_q all-zero (bubble), dmem_valid_o=0, mem_stall_o=0.
REQ-025 Reset mid-access abandons the transaction; a response after reset release is ignored.

Configuration
REQ-026 Macro MEM_MISALIGNED_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 issues no request; bundle emitted next edge with trap_valid=1, trap_mcause=4 (load) or 6 (store), trap_mtval=address.
REQ-027 Macro undefined: low address bits ignored for alignment; access proceeds with dmem_addr_o={addr[31:2],2'b00} and enables per REQ-018 truncated to 4 bits.

Verification
REQ-028 LW addr 0x100, ready same cycle, rvalid 1 cycle later, rdata 0xDEADBEEF -> load_rdata=0xDEADBEEF, stall high exactly 1 cycle.
REQ-029 LB addr 0x103, rdata 0x80FF_FFFF -> load_rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-030 SH addr 0x202, data 0x1234 -> dmem_be_o=4'b1100, dmem_wdata_o=0x12341234; ready withheld 3 cycles -> outputs stable throughout.
REQ-031 LW with no rvalid -> after 16 WAIT_RESP cycles trap_valid=1, mcause=5, mtval=address; later rvalid ignored.
REQ-032 Flush asserted in WAIT_RESP -> bubble output after response, rd_addr=0, no trap.
REQ-033 With MEM_MISALIGNED_TRAP_EN, LW addr 0x101 -> dmem_valid_o never high, trap_valid=1, mcause=4, mtval=0x101.
